// File: rtl/tri_plat_pkg.sv
// Shared definitions for the tri_plat_pipe multi-stage flush-bypass pipeline.
package tri_plat_pkg;

  // Largest supported stage count.
  localparam int TRI_PLAT_MAX_DEPTH = 8;

  // Widest payload the parity helper accepts (payload is zero-extended to this).
  localparam int TRI_PLAT_PAR_W = 64;

  // Lowest tap bit occupied by stage k when each stage is w bits wide.
  function automatic int tap_base(input int k, input int w);
    return k * w;
  endfunction

  // Even-parity bit: makes the total count of ones (data plus parity) even.
  // Zero-extension does not change the result.
  function automatic logic even_parity(input logic [TRI_PLAT_PAR_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tri_plat_stage.sv
// One register stage of tri_plat_pipe: payload, valid, flush bypass mux and
// the rst > kill > act update priority. With TRI_PLAT_PIPE_PARITY_EN defined the
// stage also stores an even-parity bit and reports a registered parity error.
module tri_plat_stage
  import tri_plat_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             act_i,
  input  logic             kill_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             val_i,
  output logic [WIDTH-1:0] data_o,
  output logic             val_o
`ifdef TRI_PLAT_PIPE_PARITY_EN
  ,
  input  logic             inj_i,
  output logic             par_err_o
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q, val_d;

  // Next state: payload follows act even while kill clears the valid.
  always_comb begin
    data_d = data_q;
    val_d  = val_q;
    if (act_i) begin
      data_d = data_i;
    end
    if (kill_i) begin
      val_d = 1'b0;
    end else if (act_i) begin
      val_d = val_i;
    end
  end

  // State register with synchronous reset to INIT / invalid.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      data_q <= INIT;
      val_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      val_q  <= val_d;
    end
  end

  // A flushed stage is transparent but keeps capturing underneath.
  assign data_o = flush_i ? data_i : data_q;
  assign val_o  = flush_i ? val_i  : val_q;

`ifdef TRI_PLAT_PIPE_PARITY_EN
  logic par_q, par_d;
  logic par_err_q, par_err_d;

  // Parity is generated from this stage's input; inj_i forces a bad bit.
  always_comb begin
    par_d     = par_q;
    par_err_d = 1'b0;
    if (act_i) begin
      par_d = even_parity(TRI_PLAT_PAR_W'(data_i)) ^ inj_i;
    end
    // Only a live, unbypassed register can report an error.
    if (val_q && !flush_i &&
        (even_parity(TRI_PLAT_PAR_W'(data_q)) != par_q)) begin
      par_err_d = 1'b1;
    end
  end

  // Parity bit and registered error flag; reset parity matches INIT.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      par_q     <= even_parity(TRI_PLAT_PAR_W'(INIT));
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/tri_plat_pipe.sv
// tri_plat_pipe: DEPTH-stage payload+valid pipeline where every stage can be
// bypassed combinationally (flush), with shared advance (act), synchronous valid
// kill and per-stage post-bypass taps. Optional parity: TRI_PLAT_PIPE_PARITY_EN.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif

module tri_plat_pipe
  import tri_plat_pkg::*;
#(
  parameter int               WIDTH  = 1,
  parameter int               OFFSET = 0,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic [0:`NCLK_WIDTH-1]        nclk,
  input  logic                          rst,
  inout  wire                           vd,
  inout  wire                           gd,
  input  logic                          act,
  input  logic                          kill,
  input  logic [0:DEPTH-1]              flush,
  input  logic [OFFSET:OFFSET+WIDTH-1]  din,
  input  logic                          din_val,
  output logic [OFFSET:OFFSET+WIDTH-1]  q,
  output logic                          q_val,
  output logic [0:DEPTH*WIDTH-1]        tap,
  output logic [0:DEPTH-1]              tap_val
`ifdef TRI_PLAT_PIPE_PARITY_EN
  ,
  input  logic                          par_inj,
  output logic [0:DEPTH-1]              par_err
`endif
);

  // Only nclk[0] clocks the block; the rest of the bundle and the supply pins
  // are carried for interface compatibility.
  logic clk;
  assign clk = nclk[0];

  logic unused_pins;
  assign unused_pins = ^{vd, gd, nclk};

  // chain_*[k] is the input of stage k; chain_*[k+1] is its post-bypass output.
  logic [WIDTH-1:0] chain_data [0:DEPTH];
  logic             chain_val  [0:DEPTH];

  assign chain_data[0] = din;
  assign chain_val[0]  = din_val;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      tri_plat_stage #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
      ) u_stage (
        .clk       (clk),
        .rst_i     (rst),
        .act_i     (act),
        .kill_i    (kill),
        .flush_i   (flush[gi]),
        .data_i    (chain_data[gi]),
        .val_i     (chain_val[gi]),
        .data_o    (chain_data[gi+1]),
        .val_o     (chain_val[gi+1])
`ifdef TRI_PLAT_PIPE_PARITY_EN
        ,
        .inj_i     ((gi == 0) ? par_inj : 1'b0),
        .par_err_o (par_err[gi])
`endif
      );

      assign tap[tap_base(gi, WIDTH) +: WIDTH] = chain_data[gi+1];
      assign tap_val[gi]                       = chain_val[gi+1];
    end
  endgenerate

  assign q     = chain_data[DEPTH];
  assign q_val = chain_val[DEPTH];

endmodule
